// File: rtl/mips32_pkg.sv
// mips32_pkg -- shared definitions for the MIPS32 memory arbiter.
// Holds the arbiter FSM state encoding and the requester IDs.
// It also has a small helper that counts how many requests are active at once.
package mips32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_IF = 2'd0;
  localparam req_id_t REQ_DM = 2'd1;
  localparam req_id_t REQ_LD = 2'd2;

  // Number of simultaneously active requesters (0..3).
  function automatic logic [1:0] count_reqs(input logic a, input logic b, input logic c);
    return 2'({1'b0, a} + {1'b0, b} + {1'b0, c});
  endfunction

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// mips32_mem_arbiter_if -- bundle of requester handshakes and RAM port signals.
// The interface groups the signals into three sets:
//   fetch  : if_req, if_addr -> if_gnt, if_rvalid
//   data   : dm_req, dm_we, dm_addr, dm_wdata -> dm_gnt, dm_rvalid
//   loader : ld_req, ld_addr, ld_wdata -> ld_gnt
// It also carries the shared return bus, the hold signal and the RAM port:
//   shared : rdata, cpu_hold
//   RAM    : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata (1-cycle read latency)
// Modports:
//   slave  -- the arbiter side.
//   master -- the requesters and the RAM side.
interface mips32_mem_arbiter_if #(
  parameter int AW = 10
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;

  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_gnt;

  logic [31:0]   rdata;
  logic          cpu_hold;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           ld_req, ld_addr, ld_wdata, mem_rdata,
    output if_gnt, if_rvalid, dm_gnt, dm_rvalid, ld_gnt, rdata, cpu_hold,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           ld_req, ld_addr, ld_wdata, mem_rdata,
    input  if_gnt, if_rvalid, dm_gnt, dm_rvalid, ld_gnt, rdata, cpu_hold,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter -- arbitrates a single-port synchronous RAM between three requesters.
// The requesters are instruction fetch (IF), load/store (DM) and the program loader (LD).
// Parameters:
//   AW         -- word-address width; it must match the AW of the connected interface.
//   STARVE_MAX -- number of consecutive arbitrations IF may lose before it is forced to win.
// Ports:
//   clk1 -- sole clock.
//   rst  -- asynchronous, active-high reset.
//   bus  -- mips32_mem_arbiter_if.slave; carries the requester handshakes, the shared
//           rdata and cpu_hold, and the RAM port.
// Optional feature (macro MEM_ARB_PERF_EN):
//   Adds the output conflict_cnt[15:0], a saturating count of IDLE arbitrations
//   that saw two or more requests.
// Behaviour:
//   Each access runs IDLE -> ISSUE -> (RESP for reads) -> IDLE.
//   The winner is registered at the IDLE edge.
//   Its command and grant are driven during ISSUE.
//   For reads, the RAM data is returned with rvalid during RESP.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int AW         = 10,
  parameter int STARVE_MAX = 3
) (
  input  logic                   clk1,
  input  logic                   rst,
  mips32_mem_arbiter_if.slave    bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]            conflict_cnt
`endif
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e    state_q, state_d;
  req_id_t       owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [SW-1:0] starve_q, starve_d;

  logic any_req;
  logic if_wins;

  assign any_req = bus.if_req | bus.dm_req | bus.ld_req;
  // IF beats DM only once it has lost STARVE_MAX arbitrations in a row.
  assign if_wins = bus.if_req & (~bus.dm_req | (starve_q == STARVE_LIM));

  // State register and captured command of the current owner.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= REQ_IF;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
    end
  end

  // Next state.
  // Arbitration and starvation bookkeeping happen only in IDLE.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.if_req) starve_d = '0;
        if (any_req) begin
          state_d = ST_ISSUE;
          if (bus.ld_req) begin
            owner_d = REQ_LD;
            we_d    = 1'b1;
            addr_d  = bus.ld_addr;
            wdata_d = bus.ld_wdata;
          end else if (if_wins) begin
            owner_d = REQ_IF;
            we_d    = 1'b0;
            addr_d  = bus.if_addr;
            wdata_d = '0;
          end else begin
            owner_d = REQ_DM;
            we_d    = bus.dm_we;
            addr_d  = bus.dm_addr;
            wdata_d = bus.dm_wdata;
          end
          if (bus.if_req) begin
            if (owner_d == REQ_IF) starve_d = '0;
            else if (starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
          end
        end
      end
      ST_ISSUE: state_d = we_q ? ST_IDLE : ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from registered state only.
  // As a result, reset clears them as soon as state_q returns to IDLE.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.if_gnt    = 1'b0;
    bus.dm_gnt    = 1'b0;
    bus.ld_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.dm_rvalid = 1'b0;
    bus.rdata     = '0;
    if (state_q == ST_ISSUE) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = we_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.if_gnt    = (owner_q == REQ_IF);
      bus.dm_gnt    = (owner_q == REQ_DM);
      bus.ld_gnt    = (owner_q == REQ_LD);
    end else if (state_q == ST_RESP) begin
      bus.rdata     = bus.mem_rdata;
      bus.if_rvalid = (owner_q == REQ_IF);
      bus.dm_rvalid = (owner_q == REQ_DM);
    end
  end

  // The CPU is held while the loader asks for, or still owns, the memory.
  // cpu_hold is forced low during reset.
  assign bus.cpu_hold = ~rst & (bus.ld_req | ((owner_q == REQ_LD) & (state_q != ST_IDLE)));

`ifdef MEM_ARB_PERF_EN
  logic [15:0] conflict_q;

  // Counts arbitrations where two or more requesters competed; saturates.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      conflict_q <= '0;
    end else if ((state_q == ST_IDLE) &&
                 (count_reqs(bus.if_req, bus.dm_req, bus.ld_req) >= 2'd2) &&
                 (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter -- directed self-checking bench for mips32_mem_arbiter.
// The bench models the synchronous RAM itself, with a 1-cycle read latency.
// Inputs are driven at the falling edge and outputs are sampled there.
module tb_mips32_mem_arbiter;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   passes = 0;

  logic [31:0] mem [0:1023];

  mips32_mem_arbiter_if #(.AW(10)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [15:0] conflict_cnt;
`endif

  mips32_mem_arbiter #(.AW(10), .STARVE_MAX(3)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  // Clock generator: 10 ns period.
  always #5 clk1 = ~clk1;

  // Synchronous RAM model with a 1-cycle read latency.
  always @(posedge clk1) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  // Checks outputs while reset is held, then checks the design stays idle after release.
  task automatic test_reset();
    repeat (2) @(negedge clk1);
    checks++; if ({bus.if_gnt, bus.dm_gnt, bus.ld_gnt} !== 3'b000) $display("[TB] FAIL reset_gnt: got %b expected %b", {bus.if_gnt, bus.dm_gnt, bus.ld_gnt}, 3'b000); else passes++;
    checks++; if ({bus.if_rvalid, bus.dm_rvalid} !== 2'b00) $display("[TB] FAIL reset_rvalid: got %b expected %b", {bus.if_rvalid, bus.dm_rvalid}, 2'b00); else passes++;
    checks++; if ({bus.mem_en, bus.mem_we} !== 2'b00) $display("[TB] FAIL reset_mem_en_we: got %b expected %b", {bus.mem_en, bus.mem_we}, 2'b00); else passes++;
    checks++; if (bus.mem_addr !== 10'd0) $display("[TB] FAIL reset_mem_addr: got %h expected %h", bus.mem_addr, 10'd0); else passes++;
    checks++; if (bus.mem_wdata !== 32'd0) $display("[TB] FAIL reset_mem_wdata: got %h expected %h", bus.mem_wdata, 32'd0); else passes++;
    checks++; if (bus.rdata !== 32'd0) $display("[TB] FAIL reset_rdata: got %h expected %h", bus.rdata, 32'd0); else passes++;
    checks++; if (bus.cpu_hold !== 1'b0) $display("[TB] FAIL reset_cpu_hold: got %b expected %b", bus.cpu_hold, 1'b0); else passes++;
    rst = 1'b0;
    @(negedge clk1);
    checks++; if (bus.mem_en !== 1'b0) $display("[TB] FAIL idle_mem_en: got %b expected %b", bus.mem_en, 1'b0); else passes++;
  endtask

  // Fetch from word 5: the grant follows one cycle after sampling, the data two cycles after.
  task automatic test_if_fetch();
    @(negedge clk1);
    bus.if_req = 1'b1; bus.if_addr = 10'd5;
    @(negedge clk1);
    checks++; if ({bus.if_gnt, bus.dm_gnt, bus.ld_gnt} !== 3'b100) $display("[TB] FAIL fetch_gnt: got %b expected %b", {bus.if_gnt, bus.dm_gnt, bus.ld_gnt}, 3'b100); else passes++;
    checks++; if ({bus.mem_en, bus.mem_we} !== 2'b10) $display("[TB] FAIL fetch_mem_cmd: got %b expected %b", {bus.mem_en, bus.mem_we}, 2'b10); else passes++;
    checks++; if (bus.mem_addr !== 10'd5) $display("[TB] FAIL fetch_mem_addr: got %h expected %h", bus.mem_addr, 10'd5); else passes++;
    bus.if_req = 1'b0;
    @(negedge clk1);
    checks++; if ({bus.if_rvalid, bus.dm_rvalid} !== 2'b10) $display("[TB] FAIL fetch_rvalid: got %b expected %b", {bus.if_rvalid, bus.dm_rvalid}, 2'b10); else passes++;
    checks++; if (bus.rdata !== 32'h28010064) $display("[TB] FAIL fetch_rdata: got %h expected %h", bus.rdata, 32'h28010064); else passes++;
    checks++; if ({bus.mem_en, bus.if_gnt} !== 2'b00) $display("[TB] FAIL fetch_resp_idle_bus: got %b expected %b", {bus.mem_en, bus.if_gnt}, 2'b00); else passes++;
    @(negedge clk1);
    checks++; if (bus.if_rvalid !== 1'b0) $display("[TB] FAIL fetch_rvalid_drop: got %b expected %b", bus.if_rvalid, 1'b0); else passes++;
    checks++; if (bus.rdata !== 32'd0) $display("[TB] FAIL fetch_rdata_zero: got %h expected %h", bus.rdata, 32'd0); else passes++;
  endtask

  // A store (55 to word 200) and a fetch arrive together: DM goes first, IF at the next IDLE.
  task automatic test_store_vs_if();
    @(negedge clk1);
    bus.if_req = 1'b1; bus.if_addr = 10'd7;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'd200; bus.dm_wdata = 32'd55;
    @(negedge clk1);
    checks++; if ({bus.if_gnt, bus.dm_gnt, bus.ld_gnt} !== 3'b010) $display("[TB] FAIL store_gnt: got %b expected %b", {bus.if_gnt, bus.dm_gnt, bus.ld_gnt}, 3'b010); else passes++;
    checks++; if ({bus.mem_en, bus.mem_we} !== 2'b11) $display("[TB] FAIL store_mem_cmd: got %b expected %b", {bus.mem_en, bus.mem_we}, 2'b11); else passes++;
    checks++; if (bus.mem_addr !== 10'd200) $display("[TB] FAIL store_mem_addr: got %h expected %h", bus.mem_addr, 10'd200); else passes++;
    checks++; if (bus.mem_wdata !== 32'd55) $display("[TB] FAIL store_mem_wdata: got %h expected %h", bus.mem_wdata, 32'd55); else passes++;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    @(negedge clk1);
    checks++; if (mem[200] !== 32'd55) $display("[TB] FAIL store_mem200: got %h expected %h", mem[200], 32'd55); else passes++;
    checks++; if ({bus.mem_en, bus.if_gnt} !== 2'b00) $display("[TB] FAIL store_idle_after_write: got %b expected %b", {bus.mem_en, bus.if_gnt}, 2'b00); else passes++;
    @(negedge clk1);
    checks++; if ({bus.if_gnt, bus.dm_gnt, bus.ld_gnt} !== 3'b100) $display("[TB] FAIL store_then_if_gnt: got %b expected %b", {bus.if_gnt, bus.dm_gnt, bus.ld_gnt}, 3'b100); else passes++;
    bus.if_req = 1'b0;
    @(negedge clk1);
    checks++; if (bus.rdata !== 32'hA5A50007) $display("[TB] FAIL store_then_if_rdata: got %h expected %h", bus.rdata, 32'hA5A50007); else passes++;
    @(negedge clk1);
  endtask

  // DM and IF are held continuously: IF must win every 4th arbitration.
  task automatic test_starvation();
    logic [1:0] exp_g;
    logic       found;
    @(negedge clk1);
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd10;
    bus.if_req = 1'b1; bus.if_addr = 10'd5;
    for (int k = 0; k < 8; k++) begin
      found = 1'b0;
      for (int c = 0; c < 5 && !found; c++) begin
        @(negedge clk1);
        if (bus.if_gnt || bus.dm_gnt || bus.ld_gnt) found = 1'b1;
      end
      exp_g = ((k % 4) == 3) ? 2'b10 : 2'b01;
      checks++;
      if (!found) $display("[TB] FAIL starve_arb%0d: got no grant within 5 cycles, expected {if,dm}=%b", k, exp_g);
      else if ({bus.if_gnt, bus.dm_gnt} !== exp_g) $display("[TB] FAIL starve_arb%0d: got {if,dm}=%b expected %b", k, {bus.if_gnt, bus.dm_gnt}, exp_g);
      else passes++;
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    repeat (3) @(negedge clk1);
  endtask

  // The loader beats IF and DM and holds the CPU until its write is done.
  task automatic test_loader();
    @(negedge clk1);
    bus.ld_req = 1'b1; bus.ld_addr = 10'd300; bus.ld_wdata = 32'hDEADBEEF;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd10;
    bus.if_req = 1'b1; bus.if_addr = 10'd5;
    #1;
    checks++; if (bus.cpu_hold !== 1'b1) $display("[TB] FAIL ld_hold_on_req: got %b expected %b", bus.cpu_hold, 1'b1); else passes++;
    @(negedge clk1);
    checks++; if ({bus.if_gnt, bus.dm_gnt, bus.ld_gnt} !== 3'b001) $display("[TB] FAIL ld_gnt: got %b expected %b", {bus.if_gnt, bus.dm_gnt, bus.ld_gnt}, 3'b001); else passes++;
    checks++; if ({bus.mem_en, bus.mem_we} !== 2'b11) $display("[TB] FAIL ld_mem_cmd: got %b expected %b", {bus.mem_en, bus.mem_we}, 2'b11); else passes++;
    bus.ld_req = 1'b0;
    #1;
    checks++; if (bus.cpu_hold !== 1'b1) $display("[TB] FAIL ld_hold_while_owner: got %b expected %b", bus.cpu_hold, 1'b1); else passes++;
    @(negedge clk1);
    checks++; if (bus.cpu_hold !== 1'b0) $display("[TB] FAIL ld_hold_release: got %b expected %b", bus.cpu_hold, 1'b0); else passes++;
    checks++; if (mem[300] !== 32'hDEADBEEF) $display("[TB] FAIL ld_mem300: got %h expected %h", mem[300], 32'hDEADBEEF); else passes++;
    @(negedge clk1);
    checks++; if ({bus.if_gnt, bus.dm_gnt, bus.ld_gnt} !== 3'b010) $display("[TB] FAIL ld_next_dm_gnt: got %b expected %b", {bus.if_gnt, bus.dm_gnt, bus.ld_gnt}, 3'b010); else passes++;
    bus.dm_req = 1'b0;
    @(negedge clk1);
    checks++; if (bus.dm_rvalid !== 1'b1 || bus.rdata !== 32'h12345678) $display("[TB] FAIL ld_next_dm_load: got rvalid=%b rdata=%h expected rvalid=1 rdata=%h", bus.dm_rvalid, bus.rdata, 32'h12345678); else passes++;
    repeat (2) @(negedge clk1);
    checks++; if (bus.if_gnt !== 1'b1) $display("[TB] FAIL ld_final_if_gnt: got %b expected %b", bus.if_gnt, 1'b1); else passes++;
    bus.if_req = 1'b0;
    repeat (2) @(negedge clk1);
  endtask

  // Reset hits as a load enters RESP: no rvalid, outputs zero at once, FSM back in IDLE.
  task automatic test_reset_during_resp();
    @(negedge clk1);
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd10;
    @(negedge clk1);
    checks++; if (bus.dm_gnt !== 1'b1) $display("[TB] FAIL rstresp_dm_gnt: got %b expected %b", bus.dm_gnt, 1'b1); else passes++;
    bus.dm_req = 1'b0;
    @(posedge clk1);
    rst = 1'b1;
    #1;
    checks++; if ({bus.if_rvalid, bus.dm_rvalid} !== 2'b00) $display("[TB] FAIL rstresp_rvalid: got %b expected %b", {bus.if_rvalid, bus.dm_rvalid}, 2'b00); else passes++;
    checks++; if (bus.rdata !== 32'd0) $display("[TB] FAIL rstresp_rdata: got %h expected %h", bus.rdata, 32'd0); else passes++;
    checks++; if ({bus.mem_en, bus.mem_we, bus.if_gnt, bus.dm_gnt, bus.ld_gnt} !== 5'b00000) $display("[TB] FAIL rstresp_cmd_gnt: got %b expected %b", {bus.mem_en, bus.mem_we, bus.if_gnt, bus.dm_gnt, bus.ld_gnt}, 5'b00000); else passes++;
    @(negedge clk1);
    checks++; if (bus.dm_rvalid !== 1'b0) $display("[TB] FAIL rstresp_rvalid_later: got %b expected %b", bus.dm_rvalid, 1'b0); else passes++;
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 10'd5;
    @(negedge clk1);
    checks++; if ({bus.if_gnt, bus.dm_gnt, bus.ld_gnt} !== 3'b100) $display("[TB] FAIL rstresp_idle_regrant: got %b expected %b", {bus.if_gnt, bus.dm_gnt, bus.ld_gnt}, 3'b100); else passes++;
    bus.if_req = 1'b0;
    @(negedge clk1);
    checks++; if (bus.rdata !== 32'h28010064) $display("[TB] FAIL rstresp_fetch_rdata: got %h expected %h", bus.rdata, 32'h28010064); else passes++;
    repeat (2) @(negedge clk1);
  endtask

  // Safety net: the run must always terminate on its own.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "[TB] timeout");
  end

  // Main sequence.
  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[5]  = 32'h28010064;
    mem[7]  = 32'hA5A50007;
    mem[10] = 32'h12345678;
    test_reset();
    test_if_fetch();
    test_store_vs_if();
    test_starvation();
    test_loader();
    test_reset_during_resp();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mips32_mem_arbiter.md
MIPS32_MEM_ARBITER -- requirements
Module: mips32_mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, memory word-address width.
REQ-002 SHALL have parameter STARVE_MAX, default 3, consecutive lost IF arbitrations before IF is forced to win.
REQ-003 SHALL have port clk1  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port if_req  in  1  instruction-fetch read request, held until if_gnt.
REQ-006 SHALL have port if_addr  in  AW  fetch word address.
REQ-007 SHALL have port if_gnt  out  1  fetch command issued this cycle.
REQ-008 SHALL have port if_rvalid  out  1  rdata holds fetch data this cycle.
REQ-009 SHALL have port dm_req  in  1  load/store request, held until dm_gnt.
REQ-010 SHALL have port dm_we  in  1  1 = store, 0 = load.
REQ-011 SHALL have port dm_addr  in  AW  data word address.
REQ-012 SHALL have port dm_wdata  in  32  store data.
REQ-013 SHALL have port dm_gnt  out  1  data command issued this cycle.
REQ-014 SHALL have port dm_rvalid  out  1  rdata holds load data this cycle.
REQ-015 SHALL have port ld_req  in  1  program-loader write request, held until ld_gnt.
REQ-016 SHALL have port ld_addr  in  AW  loader word address.
REQ-017 SHALL have port ld_wdata  in  32  loader write data.
REQ-018 SHALL have port ld_gnt  out  1  loader write issued this cycle.
REQ-019 SHALL have port rdata  out  32  shared read-return bus.
REQ-020 SHALL have port cpu_hold  out  1  high while ld_req is high or the loader owns the memory.
REQ-021 SHALL have ports mem_en, mem_we (out 1), mem_addr (out AW), mem_wdata (out 32), mem_rdata (in 32): single-port synchronous RAM with 1-cycle read latency.

Function
REQ-022 SHALL use FSM IDLE -> ISSUE -> (read: RESP -> IDLE | write: IDLE); arbitration occurs only in IDLE.
REQ-023 SHALL, at the IDLE edge with any request, register the winner and drive mem_en=1, mem_we/addr/wdata from the winner, and the winner's gnt=1 for exactly the ISSUE cycle.
REQ-024 SHALL, in RESP, drive rdata=mem_rdata and the owner's rvalid=1 for one cycle; rdata=0 otherwise.
REQ-025 SHALL have a latency of req sampled -> gnt of 1 cycle and req sampled -> rvalid of 2 cycles; each access occupies 2 (write) or 3 (read) cycles.
REQ-026 SHALL use fixed priority LD > DM > IF, except IF wins over DM when the starvation counter equals STARVE_MAX; LD always wins.
REQ-027 SHALL increment the starvation counter (saturating) on each IDLE arbitration where if_req=1 and IF loses, and clear it when IF is granted or if_req=0 at arbitration.
REQ-028 SHALL ignore requests outside IDLE; a requester deasserting before its gnt is dropped without error.
REQ-029 SHALL never assert more than one gnt or rvalid in any cycle; mem_en=0 outside ISSUE.

Reset
REQ-030 SHALL, on rst, go immediately to IDLE with all gnt/rvalid=0, mem_en=mem_we=0, mem_addr/mem_wdata/rdata=0, cpu_hold=0, starvation counter=0; an in-flight access is abandoned with no rvalid.

Configuration
REQ-031 SHALL, with MEM_ARB_PERF_EN defined, add output conflict_cnt (16 bits, saturating, reset 0) counting IDLE arbitrations with two or more requests; without the macro, no port or logic exists.

Structure
REQ-032 SHALL place the FSM state enum and requester-ID constants (REQ_IF, REQ_DM, REQ_LD) in shared package mips32_pkg; no sub-module is required (priority selection stays inline).

Verification
REQ-033 SHALL cover: if_req, if_addr=5, mem[5]=0x28010064 -> if_gnt 1 cycle later, if_rvalid with rdata=0x28010064 2 cycles after sampling.
REQ-034 SHALL cover: simultaneous if_req and dm_req store (addr 200, data 55) -> dm_gnt first, mem[200]=55, IF granted at the next IDLE.
REQ-035 SHALL cover: dm_req held continuously with if_req held -> IF granted on every 4th arbitration (STARVE_MAX=3).
REQ-036 SHALL cover: ld_req with all three requesters active -> ld_gnt first, cpu_hold=1 until the loader write completes.
REQ-037 SHALL cover: rst asserted during RESP of a load -> dm_rvalid never asserted, all outputs 0 immediately, FSM in IDLE.
